// File: rtl/snake_io_frontend.sv
// snake_io_frontend
// Board-facing front end for the Snake game: free-running tick strobes,
// five button debouncers producing one-cycle press pulses, and a 640x480
// VGA renderer that draws walls, snake pieces and food from the grid state.
// Build macro BORDER_DRAW_EN: when defined, wall cells render 0x92; when
// undefined, wall cells fall through to background.
module snake_io_frontend #(
   parameter int GRID_WIDTH      = 40,
   parameter int GRID_HEIGHT     = 30,
   parameter int NUM_PIECES      = 16,
   parameter int BLOCK_PX        = 16,
   parameter int CLK_PER_PIXEL   = 4,
   parameter int GAME_DIV        = 12500000,
   parameter int FAST_DIV        = 100000,
   parameter int DEBOUNCE_CYCLES = 1000000,
   localparam int YB = $clog2(GRID_HEIGHT),
   localparam int XB = $clog2(GRID_WIDTH)
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   ButtonLeft,
   input  logic                   ButtonRight,
   input  logic                   ButtonUp,
   input  logic                   ButtonDown,
   input  logic                   ButtonCenter,
   output logic                   LeftPressed,
   output logic                   RightPressed,
   output logic                   UpPressed,
   output logic                   DownPressed,
   output logic                   CenterPressed,
   output logic                   GameTick,
   output logic                   FastTick,
   input  logic [YB*NUM_PIECES-1:0] packSnakeY,
   input  logic [XB*NUM_PIECES-1:0] packSnakeX,
   input  logic [YB-1:0]          foodY,
   input  logic [XB-1:0]          foodX,
   output logic [0:7]             RGB,
   output logic                   HSync,
   output logic                   VSync
);

   localparam int GW = (GAME_DIV > 1) ? $clog2(GAME_DIV) : 1;
   localparam int FW = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int PW = (CLK_PER_PIXEL > 1) ? $clog2(CLK_PER_PIXEL) : 1;

   // 640x480@60 timing, in pixels and lines
   localparam int H_VISIBLE    = 640;
   localparam int H_SYNC_START = 656;
   localparam int H_SYNC_END   = 751;
   localparam int H_TOTAL      = 800;
   localparam int V_VISIBLE    = 480;
   localparam int V_SYNC_START = 490;
   localparam int V_SYNC_END   = 491;
   localparam int V_TOTAL      = 525;

   // ---------------- tick generators ----------------
   logic [GW-1:0] game_cnt_q, game_cnt_d;
   logic [FW-1:0] fast_cnt_q, fast_cnt_d;
   logic          game_tick_q, game_tick_d;
   logic          fast_tick_q, fast_tick_d;

   // Strobe is registered on the wrap edge, so it lands on cycle DIV after reset
   always_comb begin
      game_tick_d = (game_cnt_q == GW'(GAME_DIV - 1));
      game_cnt_d  = game_tick_d ? '0 : game_cnt_q + 1'b1;
      fast_tick_d = (fast_cnt_q == FW'(FAST_DIV - 1));
      fast_cnt_d  = fast_tick_d ? '0 : fast_cnt_q + 1'b1;
   end

   // Tick counter and strobe registers
   always_ff @(posedge Clock) begin
      if (Reset) begin
         game_cnt_q  <= '0;
         fast_cnt_q  <= '0;
         game_tick_q <= 1'b0;
         fast_tick_q <= 1'b0;
      end else begin
         game_cnt_q  <= game_cnt_d;
         fast_cnt_q  <= fast_cnt_d;
         game_tick_q <= game_tick_d;
         fast_tick_q <= fast_tick_d;
      end
   end

   assign GameTick = game_tick_q;
   assign FastTick = fast_tick_q;

   // ---------------- debouncers ----------------
   // bit order: 0 left, 1 right, 2 up, 3 down, 4 center
   logic [4:0]    btn_raw;
   logic [4:0]    sync1_q, sync2_q;
   logic [4:0]    stable_q, stable_d;
   logic [4:0]    press_q, press_d;
   logic [DW-1:0] deb_cnt_q [5];
   logic [DW-1:0] deb_cnt_d [5];

   assign btn_raw = {ButtonCenter, ButtonDown, ButtonUp, ButtonRight, ButtonLeft};

   // Count consecutive disagreeing samples; accept the new level after DEBOUNCE_CYCLES of them
   always_comb begin
      stable_d = stable_q;
      press_d  = '0;
      for (int b = 0; b < 5; b++) begin
         deb_cnt_d[b] = deb_cnt_q[b];
         if (sync2_q[b] == stable_q[b]) begin
            deb_cnt_d[b] = '0;
         end else if (deb_cnt_q[b] == DW'(DEBOUNCE_CYCLES - 1)) begin
            deb_cnt_d[b] = '0;
            stable_d[b]  = sync2_q[b];
            press_d[b]   = sync2_q[b];
         end else begin
            deb_cnt_d[b] = deb_cnt_q[b] + 1'b1;
         end
      end
   end

   // Synchronizer, stable level, counter and press pulse registers
   always_ff @(posedge Clock) begin
      if (Reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         press_q  <= '0;
         for (int b = 0; b < 5; b++) deb_cnt_q[b] <= '0;
      end else begin
         sync1_q  <= btn_raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         press_q  <= press_d;
         for (int b = 0; b < 5; b++) deb_cnt_q[b] <= deb_cnt_d[b];
      end
   end

   assign LeftPressed   = press_q[0];
   assign RightPressed  = press_q[1];
   assign UpPressed     = press_q[2];
   assign DownPressed   = press_q[3];
   assign CenterPressed = press_q[4];

   // ---------------- VGA timing and pixel colour ----------------
   logic [PW-1:0] pdiv_q, pdiv_d;
   logic          pix_en;
   logic [9:0]    h_q, h_d, v_q, v_d;
   logic [0:7]    rgb_q, rgb_d;
   logic          hs_q, hs_d, vs_q, vs_d;

   // Pixel enable divider and raster position advance
   always_comb begin
      pix_en = (pdiv_q == PW'(CLK_PER_PIXEL - 1));
      pdiv_d = pix_en ? '0 : pdiv_q + 1'b1;
      h_d    = h_q;
      v_d    = v_q;
      if (pix_en) begin
         if (h_q == 10'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == 10'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
         end
      end
   end

   logic [9:0] cx, cy, piece_x, piece_y;
   logic       head_hit, body_hit, food_hit, wall_hit, in_grid, visible;

   // Colour of the current raster position: head > body > food > wall > background
   always_comb begin
      cx       = h_q / 10'(BLOCK_PX);
      cy       = v_q / 10'(BLOCK_PX);
      head_hit = 1'b0;
      body_hit = 1'b0;
      piece_x  = '0;
      piece_y  = '0;
      for (int i = 0; i < NUM_PIECES; i++) begin
         piece_x = 10'(packSnakeX[i*XB +: XB]);
         piece_y = 10'(packSnakeY[i*YB +: YB]);
         // a piece parked at (0,0) is unused
         if ((piece_x != '0 || piece_y != '0) && piece_x == cx && piece_y == cy) begin
            if (i == 0) head_hit = 1'b1;
            else        body_hit = 1'b1;
         end
      end
      food_hit = (10'(foodX) == cx) && (10'(foodY) == cy);
`ifdef BORDER_DRAW_EN
      wall_hit = (cx == '0) || (cx == 10'(GRID_WIDTH - 1)) ||
                 (cy == '0) || (cy == 10'(GRID_HEIGHT - 1));
`else
      wall_hit = 1'b0;
`endif
      in_grid  = (cx < 10'(GRID_WIDTH)) && (cy < 10'(GRID_HEIGHT));
      visible  = (h_q < 10'(H_VISIBLE)) && (v_q < 10'(V_VISIBLE));
      rgb_d    = 8'h00;
      if (visible && in_grid) begin
         if (head_hit)      rgb_d = 8'hFC;
         else if (body_hit) rgb_d = 8'h1C;
         else if (food_hit) rgb_d = 8'hE0;
         else if (wall_hit) rgb_d = 8'h92;
      end
      hs_d = !((h_q >= 10'(H_SYNC_START)) && (h_q <= 10'(H_SYNC_END)));
      vs_d = !((v_q >= 10'(V_SYNC_START)) && (v_q <= 10'(V_SYNC_END)));
   end

   // Raster counters plus colour and syncs registered together on pixel enable
   always_ff @(posedge Clock) begin
      if (Reset) begin
         pdiv_q <= '0;
         h_q    <= '0;
         v_q    <= '0;
         rgb_q  <= 8'h00;
         hs_q   <= 1'b1;
         vs_q   <= 1'b1;
      end else begin
         pdiv_q <= pdiv_d;
         h_q    <= h_d;
         v_q    <= v_d;
         if (pix_en) begin
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
         end
      end
   end

   assign RGB   = rgb_q;
   assign HSync = hs_q;
   assign VSync = vs_q;

endmodule

// File: tb/tb_snake_io_frontend.sv
// Bench for snake_io_frontend: behavioural model of ticks, debouncing and
// the rendered raster, compared against the DUT every cycle, plus directed
// literal expectations at hand-picked cycles and pixels.
module tb_snake_io_frontend;

   localparam int GWID = 40;
   localparam int GHGT = 30;
   localparam int NP   = 16;
   localparam int BPX  = 16;
   localparam int CPP  = 1;
   localparam int GDIV = 10;
   localparam int FDIV = 3;
   localparam int DB   = 4;
   localparam int YB   = 5;
   localparam int XB   = 6;

   logic Clock = 1'b0;
   logic Reset;
   logic ButtonLeft, ButtonRight, ButtonUp, ButtonDown, ButtonCenter;
   logic LeftPressed, RightPressed, UpPressed, DownPressed, CenterPressed;
   logic GameTick, FastTick;
   logic [YB*NP-1:0] packSnakeY;
   logic [XB*NP-1:0] packSnakeX;
   logic [YB-1:0]    foodY;
   logic [XB-1:0]    foodX;
   logic [0:7]       RGB;
   logic             HSync, VSync;

   snake_io_frontend #(
      .GRID_WIDTH(GWID), .GRID_HEIGHT(GHGT), .NUM_PIECES(NP), .BLOCK_PX(BPX),
      .CLK_PER_PIXEL(CPP), .GAME_DIV(GDIV), .FAST_DIV(FDIV), .DEBOUNCE_CYCLES(DB)
   ) dut (
      .Clock(Clock), .Reset(Reset),
      .ButtonLeft(ButtonLeft), .ButtonRight(ButtonRight), .ButtonUp(ButtonUp),
      .ButtonDown(ButtonDown), .ButtonCenter(ButtonCenter),
      .LeftPressed(LeftPressed), .RightPressed(RightPressed), .UpPressed(UpPressed),
      .DownPressed(DownPressed), .CenterPressed(CenterPressed),
      .GameTick(GameTick), .FastTick(FastTick),
      .packSnakeY(packSnakeY), .packSnakeX(packSnakeX),
      .foodY(foodY), .foodX(foodX),
      .RGB(RGB), .HSync(HSync), .VSync(VSync)
   );

   always #5 Clock = ~Clock;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // grid contents as plain integers
   int sx[NP];
   int sy[NP];
   int fx, fy;

   // model state
   logic [4:0] hist[$];
   logic [4:0] m_stab, e_press, dut_press;
   bit         all_diff, shown, e_game, e_fast;
   int         m_rgb, m_hs, m_vs, mh, mv, n, hs_low;
   int         pcnt[5] = '{0, 0, 0, 0, 0};
   int         pcyc[5] = '{0, 0, 0, 0, 0};

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic int pix_colour(input int h, input int v);
      int cx, cy;
      if (h >= 640 || v >= 480) return 0;
      cx = h / BPX;
      cy = v / BPX;
      if (cx >= GWID || cy >= GHGT) return 0;
      if ((sx[0] != 0 || sy[0] != 0) && sx[0] == cx && sy[0] == cy) return 'hFC;
      for (int i = 1; i < NP; i++)
         if ((sx[i] != 0 || sy[i] != 0) && sx[i] == cx && sy[i] == cy) return 'h1C;
      if (fx == cx && fy == cy) return 'hE0;
`ifdef BORDER_DRAW_EN
      if (cx == 0 || cx == GWID - 1 || cy == 0 || cy == GHGT - 1) return 'h92;
`endif
      return 0;
   endfunction

   task automatic set_positions();
      packSnakeX = '0;
      packSnakeY = '0;
      for (int i = 0; i < NP; i++) begin
         packSnakeX[i*XB +: XB] = XB'(sx[i]);
         packSnakeY[i*YB +: YB] = YB'(sy[i]);
      end
      foodX = XB'(fx);
      foodY = YB'(fy);
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge Clock);
   endtask

   // Model update and comparison, 1 time unit after every active edge
   always @(posedge Clock) begin
      #1;
      if (Reset) begin
         cyc     = 0;
         m_stab  = '0;
         hist.delete();
         for (int i = 0; i < DB + 2; i++) hist.push_front(5'b0);
         m_rgb   = 0;
         m_hs    = 1;
         m_vs    = 1;
         hs_low  = 0;
         e_game  = 1'b0;
         e_fast  = 1'b0;
         e_press = '0;
         shown   = 1'b0;
      end else begin
         cyc++;
         hist.push_front({ButtonCenter, ButtonDown, ButtonUp, ButtonRight, ButtonLeft});
         void'(hist.pop_back());
         e_game = (cyc % GDIV == 0);
         e_fast = (cyc % FDIV == 0);
         // a level is accepted once DB consecutive synchronized samples disagree with it
         e_press = '0;
         for (int b = 0; b < 5; b++) begin
            all_diff = 1'b1;
            for (int i = 2; i < DB + 2; i++)
               if (hist[i][b] == m_stab[b]) all_diff = 1'b0;
            if (all_diff) begin
               m_stab[b]  = ~m_stab[b];
               e_press[b] = m_stab[b];
            end
         end
         shown = (cyc % CPP == 0);
         if (shown) begin
            n     = cyc / CPP - 1;
            mh    = n % 800;
            mv    = (n / 800) % 525;
            m_rgb = pix_colour(mh, mv);
            m_hs  = (mh >= 656 && mh <= 751) ? 0 : 1;
            m_vs  = (mv >= 490 && mv <= 491) ? 0 : 1;
         end
      end

      dut_press = {CenterPressed, DownPressed, UpPressed, RightPressed, LeftPressed};
      check("GameTick", int'(GameTick), int'(e_game));
      check("FastTick", int'(FastTick), int'(e_fast));
      check("press", int'(dut_press), int'(e_press));
      check("RGB", int'(RGB), m_rgb);
      check("HSync", int'(HSync), m_hs);
      check("VSync", int'(VSync), m_vs);

      if (!Reset) begin
         for (int b = 0; b < 5; b++)
            if (dut_press[b]) begin
               pcnt[b]++;
               pcyc[b] = cyc;
            end
         if (cyc == 3 || cyc == 6 || cyc == 9) check("FastTick_lit", int'(FastTick), 1);
         if (cyc == 10 || cyc == 20 || cyc == 30) check("GameTick_lit", int'(GameTick), 1);
         if (cyc == 11) check("GameTick_width", int'(GameTick), 0);
         if (shown) begin
            if (HSync == 1'b0) hs_low++;
            if (mh == 799) begin
               check("hsync_low_per_line", hs_low, 96);
               hs_low = 0;
            end
            if (mh == 88 && mv == 88)  check("pix_head", int'(RGB), 'hFC);
            if (mh == 72 && mv == 88)  check("pix_body", int'(RGB), 'h1C);
            if (mh == 168 && mv == 88) check("pix_food", int'(RGB), 'hE0);
            if (mh == 200 && mv == 88) check("pix_bg", int'(RGB), 'h00);
            if (mh == 700 && mv == 88) begin
               check("pix_blank", int'(RGB), 'h00);
               check("hsync_lit", int'(HSync), 0);
            end
            if (mh == 0 && mv == 0) begin
`ifdef BORDER_DRAW_EN
               check("pix_wall", int'(RGB), 'h92);
`else
               check("pix_wall", int'(RGB), 'h00);
`endif
            end
         end
      end
   end

   // Stimulus
   initial begin
      Reset = 1'b1;
      ButtonLeft = 1'b0; ButtonRight = 1'b0; ButtonUp = 1'b0;
      ButtonDown = 1'b0; ButtonCenter = 1'b0;
      for (int i = 0; i < NP; i++) begin
         sx[i] = 0;
         sy[i] = 0;
      end
      sx[0] = 5;  sy[0] = 5;
      sx[1] = 4;  sy[1] = 5;
      fx    = 10; fy    = 5;
      set_positions();
      repeat (3) @(negedge Clock);
      Reset    = 1'b0;
      ButtonUp = 1'b1;                // held for cycles 0..19
      wait_to(20);  ButtonUp = 1'b0;
      wait_to(30);  ButtonDown = 1'b1; // 2-cycle glitch
      wait_to(32);  ButtonDown = 1'b0;
      wait_to(42);  ButtonDown = 1'b1; // DB-1 cycle glitch
      wait_to(45);  ButtonDown = 1'b0;
      wait_to(55);  ButtonLeft = 1'b1; ButtonRight = 1'b1;
      wait_to(65);  ButtonLeft = 1'b0; ButtonRight = 1'b0;
      wait_to(80);  ButtonCenter = 1'b1; // exactly DB cycles
      wait_to(84);  ButtonCenter = 1'b0;
      // line 88 carries head, body and food; reset lands inside its sync pulse
      wait_to(71146); ButtonLeft = 1'b1;
      wait_to(71150); Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      wait_to(40);  ButtonLeft = 1'b0;
      wait_to(60);

      check("up_pulses", pcnt[2], 1);
      check("up_pulse_cycle", pcyc[2], 6);
      check("down_pulses", pcnt[3], 0);
      check("right_pulses", pcnt[1], 1);
      check("right_pulse_cycle", pcyc[1], 61);
      check("left_pulses", pcnt[0], 2);
      check("left_pulse_cycle_after_reset", pcyc[0], 6);
      check("center_pulses", pcnt[4], 1);
      check("center_pulse_cycle", pcyc[4], 86);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Guard against a stalled run
   initial begin
      #2000000;
      $display("FAIL watchdog: end of stimulus not reached by time %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
